// File: rtl/mc_control_if.sv
// Control bundle between the multi-cycle control FSM and the datapath/memory.
// The master side is the controller; the slave side is the datapath.
interface mc_control_if;
    logic [2:0] opcode;
    logic       flag;
    logic       mem_ready;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_ctrl;
    logic       imm_sel;
    logic       pc_write;
    logic       pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_req;
    logic       mem_we;
    logic       reg_write;
    logic       mem_to_reg;
    logic       halted;
    logic [3:0] state;

    modport master (
        input  opcode, flag, mem_ready,
        output alu_src_a, alu_src_b, alu_ctrl, imm_sel, pc_write, pc_src,
               ir_write, iord, mem_req, mem_we, reg_write, mem_to_reg,
               halted, state
    );

    modport slave (
        output opcode, flag, mem_ready,
        input  alu_src_a, alu_src_b, alu_ctrl, imm_sel, pc_write, pc_src,
               ir_write, iord, mem_req, mem_we, reg_write, mem_to_reg,
               halted, state
    );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle control FSM for the 16-bit processor: sequences fetch, decode,
// execute, memory and writeback, stalling on the memory req/ready handshake.
module mc_control (
    input  logic          clk,
    input  logic          rst,
    mc_control_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        MEM_WB   = 4'd7,
        ALU_WB   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        HALT     = 4'd11
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.alu_ctrl   = 1'b1;
        bus.imm_sel    = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 1'b0;
        bus.ir_write   = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.halted     = 1'b0;

        case (state_q)
            FETCH: begin
                // ALU computes PC+1 every fetch cycle; it is only committed on ready.
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_d      = DECODE;
                end
            end
            DECODE: begin
                // Speculatively form PC+imm into ALUOut as the branch/jump target.
                bus.alu_src_b = 2'b10;
                bus.imm_sel   = (bus.opcode == 3'b101);
                case (bus.opcode)
                    3'b000, 3'b001: state_d = EXEC_R;
                    3'b010:         state_d = EXEC_I;
                    3'b011, 3'b100: state_d = MEM_ADDR;
                    3'b101:         state_d = BRANCH;
                    3'b110:         state_d = JUMP;
                    default:        state_d = HALT;
                endcase
            end
            EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_ctrl  = ~bus.opcode[0];
                state_d       = ALU_WB;
            end
            EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = ALU_WB;
            end
            ALU_WB: begin
                bus.reg_write = 1'b1;
                state_d       = FETCH;
            end
            MEM_ADDR: begin
                // SW carries its offset in the split field since IR[6:4] holds rs2.
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.imm_sel   = (bus.opcode == 3'b100);
                state_d       = (bus.opcode == 3'b100) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                if (bus.mem_ready) state_d = MEM_WB;
            end
            MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                state_d        = FETCH;
            end
            MEM_WR: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                bus.mem_we  = 1'b1;
                if (bus.mem_ready) state_d = FETCH;
            end
            BRANCH: begin
                // A-B sign bit arrives combinationally this same cycle.
                bus.alu_src_a = 1'b1;
                bus.alu_ctrl  = 1'b0;
                bus.pc_src    = 1'b1;
                bus.pc_write  = bus.flag;
                state_d       = FETCH;
            end
            JUMP: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = 1'b1;
                state_d      = FETCH;
            end
            HALT: begin
                bus.halted = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        // Reset squashes every side effect so an in-flight store never lands.
        if (rst) begin
            bus.pc_write  = 1'b0;
            bus.ir_write  = 1'b0;
            bus.mem_req   = 1'b0;
            bus.mem_we    = 1'b0;
            bus.reg_write = 1'b0;
            bus.halted    = 1'b0;
        end
    end

    assign bus.state = state_q;
endmodule
